heap_op_scheduler: RTL and testbench

Multi-requester front end for the C3 hardware max-heap custom-instruction unit. Arbitrates push/pop commands from NREQ requesters round-robin and issues one at a time on the heap's `in_v`/`rd`/`in_data` port. Models heap occupancy so that overflow pushes and empty pops are rejected locally, and enforces a settle window so the heap finishes heapify before the next issue. Returns a tagged completion to each requester.

---
 rtl/heap_sched_pkg.sv | 27 ++
 rtl/heap_sched_rr_arb.sv | 32 +++
 rtl/heap_op_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_heap_op_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_sched_pkg.sv
// Shared opcodes, heap rd encodings, FSM state encoding and sizing helpers
// for the heap operation scheduler.
package heap_sched_pkg;

   localparam logic       OP_PUSH      = 1'b0;
   localparam logic       OP_POP       = 1'b1;
   localparam logic [4:0] HEAP_RD_PUSH = 5'd0;
   localparam logic [4:0] HEAP_RD_POP  = 5'd1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_RSP,
      SETTLE,
      RESP
   } sched_state_e;

   // Bits needed to count 0..heap_size elements inclusive.
   function automatic int occ_width(input int heap_size);
      return $clog2(heap_size + 1);
   endfunction

   function automatic int id_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/heap_sched_rr_arb.sv
// Combinational round-robin arbiter: the search starts at rr_ptr and the first
// set request wins, reported both one-hot and as a binary id.
module heap_sched_rr_arb
   import heap_sched_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req_v,
   input  logic [IDW-1:0]  rr_ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id
);

   always_comb begin : arb
      int   idx;
      logic found;
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(rr_ptr) + i) % NREQ;
         if (!found && req_v[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/heap_op_scheduler.sv
// Round-robin push/pop front end for the max-heap unit with local full/empty
// rejection, settle window and pop timeout. HEAP_SCHED_STATS_EN adds per-requester counters.
module heap_op_scheduler
   import heap_sched_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int HEAP_SIZE   = 25,
   parameter int SETTLE_CYC  = 6,
   parameter int RSP_TIMEOUT = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NREQ-1:0]                 req_v,
   input  logic [NREQ-1:0]                 req_op,
   input  logic [NREQ*32-1:0]              req_data,
   input  logic [NREQ*5-1:0]               req_rd,
   output logic [NREQ-1:0]                 req_ready,
   output logic                            heap_in_v,
   output logic [4:0]                      heap_rd,
   output logic [31:0]                     heap_in_data,
   input  logic                            heap_busy,
   input  logic                            heap_out_v,
   input  logic [31:0]                     heap_out_data,
   output logic [NREQ-1:0]                 rsp_v,
   output logic [4:0]                      rsp_rd,
   output logic [31:0]                     rsp_data,
   output logic                            rsp_err,
   output logic [occ_width(HEAP_SIZE)-1:0] occupancy,
   output logic [NREQ*16-1:0]              stat_ops,
   output logic [NREQ*16-1:0]              stat_rej
);

   localparam int OCC_W   = occ_width(HEAP_SIZE);
   localparam int IDW     = id_width(NREQ);
   localparam int CNT_MAX = (SETTLE_CYC > RSP_TIMEOUT) ? SETTLE_CYC : RSP_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   sched_state_e     state_q, state_d;
   logic             op_q, op_d, err_q, err_d;
   logic [31:0]      data_q, data_d;
   logic [4:0]       rd_q, rd_d;
   logic [IDW-1:0]   id_q, id_d, rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             heap_in_v_q, heap_in_v_d;
   logic [4:0]       heap_rd_q, heap_rd_d;
   logic [31:0]      heap_in_data_q, heap_in_data_d;
   logic [NREQ-1:0]  rsp_v_q, rsp_v_d;
   logic [4:0]       rsp_rd_q, rsp_rd_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_id;

   heap_sched_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req_v    (req_v),
      .rr_ptr   (rr_ptr_q),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign req_ready = (state_q == IDLE) ? grant : '0;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      data_d   = data_q;
      rd_d     = rd_q;
      id_d     = id_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      occ_d    = occ_q;
      rr_ptr_d = rr_ptr_q;
      cnt_dec  = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
      case (state_q)
         IDLE: begin
            if (|grant) begin
               op_d   = req_op[grant_id];
               data_d = req_data[int'(grant_id)*32 +: 32];
               rd_d   = req_rd[int'(grant_id)*5 +: 5];
               id_d   = grant_id;
               err_d  = 1'b0;
               // Boundary commands never reach the heap, so occupancy cannot wrap.
               if ((op_d == OP_PUSH && occ_q == OCC_W'(HEAP_SIZE)) ||
                   (op_d == OP_POP && occ_q == '0)) begin
                  err_d = 1'b1;
                  if (op_d == OP_POP) data_d = '0;
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (op_q == OP_PUSH) begin
               occ_d   = occ_q + 1'b1;
               cnt_d   = CNT_W'(SETTLE_CYC);
               state_d = SETTLE;
            end else begin
               occ_d   = occ_q - 1'b1;
               cnt_d   = CNT_W'(RSP_TIMEOUT);
               state_d = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (heap_out_v) begin
               data_d  = heap_out_data;
               cnt_d   = CNT_W'(SETTLE_CYC);
               state_d = SETTLE;
            end else if (cnt_dec == '0) begin
               err_d   = 1'b1;
               data_d  = '0;
               cnt_d   = CNT_W'(SETTLE_CYC);
               state_d = SETTLE;
            end else begin
               cnt_d = cnt_dec;
            end
         end
         SETTLE: begin
            // Timer holds at zero while the heap still reports busy.
            cnt_d = cnt_dec;
            if (cnt_dec == '0 && !heap_busy) state_d = RESP;
         end
         RESP: begin
            rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered off the next state so they line up with it.
      heap_in_v_d    = (state_d == ISSUE);
      heap_rd_d      = heap_rd_q;
      heap_in_data_d = heap_in_data_q;
      if (state_d == ISSUE) begin
         heap_rd_d      = (op_d == OP_POP) ? HEAP_RD_POP : HEAP_RD_PUSH;
         heap_in_data_d = data_d;
      end
      rsp_v_d    = '0;
      rsp_rd_d   = rsp_rd_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      if (state_d == RESP) begin
         rsp_v_d[id_d] = 1'b1;
         rsp_rd_d      = rd_d;
         rsp_data_d    = data_d;
         rsp_err_d     = err_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         op_q           <= 1'b0;
         data_q         <= '0;
         rd_q           <= '0;
         id_q           <= '0;
         err_q          <= 1'b0;
         cnt_q          <= '0;
         occ_q          <= '0;
         rr_ptr_q       <= '0;
         heap_in_v_q    <= 1'b0;
         heap_rd_q      <= '0;
         heap_in_data_q <= '0;
         rsp_v_q        <= '0;
         rsp_rd_q       <= '0;
         rsp_data_q     <= '0;
         rsp_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         data_q         <= data_d;
         rd_q           <= rd_d;
         id_q           <= id_d;
         err_q          <= err_d;
         cnt_q          <= cnt_d;
         occ_q          <= occ_d;
         rr_ptr_q       <= rr_ptr_d;
         heap_in_v_q    <= heap_in_v_d;
         heap_rd_q      <= heap_rd_d;
         heap_in_data_q <= heap_in_data_d;
         rsp_v_q        <= rsp_v_d;
         rsp_rd_q       <= rsp_rd_d;
         rsp_data_q     <= rsp_data_d;
         rsp_err_q      <= rsp_err_d;
      end
   end

   assign heap_in_v    = heap_in_v_q;
   assign heap_rd      = heap_rd_q;
   assign heap_in_data = heap_in_data_q;
   assign rsp_v        = rsp_v_q;
   assign rsp_rd       = rsp_rd_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_err      = rsp_err_q;
   assign occupancy    = occ_q;

`ifdef HEAP_SCHED_STATS_EN
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
      logic [15:0] ops_q, ops_d, rej_q, rej_d;

      always_comb begin
         ops_d = ops_q;
         rej_d = rej_q;
         if (req_ready[gi] && ops_q != 16'hffff) ops_d = ops_q + 16'd1;
         if (rsp_v_q[gi] && rsp_err_q && rej_q != 16'hffff) rej_d = rej_q + 16'd1;
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            ops_q <= '0;
            rej_q <= '0;
         end else begin
            ops_q <= ops_d;
            rej_q <= rej_d;
         end
      end

      assign stat_ops[gi*16 +: 16] = ops_q;
      assign stat_rej[gi*16 +: 16] = rej_q;
   end
`else
   assign stat_ops = '0;
   assign stat_rej = '0;
`endif

endmodule

// File: tb/tb_heap_op_scheduler.sv
// Directed bench for heap_op_scheduler: vector table of single commands against a
// behavioural max-heap, plus arbitration, overflow and mid-operation reset sequences.
module tb_heap_op_scheduler;

   localparam int NREQ        = 2;
   localparam int HEAP_SIZE   = 25;
   localparam int SETTLE_CYC  = 6;
   localparam int RSP_TIMEOUT = 8;
   localparam int OCC_W       = $clog2(HEAP_SIZE + 1);

   logic               clk;
   logic               reset;
   logic [NREQ-1:0]    req_v, req_op, req_ready, rsp_v;
   logic [NREQ*32-1:0] req_data;
   logic [NREQ*5-1:0]  req_rd;
   logic               heap_in_v, heap_busy, heap_out_v, rsp_err;
   logic [4:0]         heap_rd, rsp_rd;
   logic [31:0]        heap_in_data, heap_out_data, rsp_data;
   logic [OCC_W-1:0]   occupancy;
   logic [NREQ*16-1:0] stat_ops, stat_rej;

   heap_op_scheduler #(
      .NREQ(NREQ), .HEAP_SIZE(HEAP_SIZE), .SETTLE_CYC(SETTLE_CYC), .RSP_TIMEOUT(RSP_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_v(req_v), .req_op(req_op), .req_data(req_data), .req_rd(req_rd),
      .req_ready(req_ready),
      .heap_in_v(heap_in_v), .heap_rd(heap_rd), .heap_in_data(heap_in_data),
      .heap_busy(heap_busy), .heap_out_v(heap_out_v), .heap_out_data(heap_out_data),
      .rsp_v(rsp_v), .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .occupancy(occupancy), .stat_ops(stat_ops), .stat_rej(stat_rej)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int issue_cnt = 0;
   logic resp_en;

   // Behavioural max-heap: answers a pop one cycle after the issue cycle.
   logic [31:0] hq[$];
   logic        pending = 1'b0;
   logic [31:0] pend_val = '0;
   always @(negedge clk or posedge reset) begin
      if (reset) begin
         hq.delete();
         pending       = 1'b0;
         heap_out_v    = 1'b0;
         heap_out_data = '0;
      end else begin
         heap_out_v = 1'b0;
         if (pending) begin
            heap_out_v    = 1'b1;
            heap_out_data = pend_val;
            pending       = 1'b0;
         end
         if (heap_in_v) begin
            issue_cnt++;
            if (heap_rd == 5'd0) begin
               hq.push_back(heap_in_data);
            end else if (heap_rd == 5'd1 && hq.size() > 0) begin
               int mi;
               mi = 0;
               for (int i = 1; i < hq.size(); i++) if (hq[i] > hq[mi]) mi = i;
               if (resp_en) begin
                  pending  = 1'b1;
                  pend_val = hq[mi];
               end
               hq.delete(mi);
            end
         end
      end
   end

   typedef struct {
      int          id;
      logic        op;
      logic [31:0] data;
      logic [4:0]  rd;
      int          nbusy;
      logic        resp_en;
      int          lat;
      logic        err;
      logic        chk_data;
      logic [31:0] rdata;
      int          occ;
      int          iss;
   } vec_t;

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
      end
   endtask

   // Issue one command, wait for its response, compare everything against the vector.
   task automatic exec(input vec_t v, input string tag);
      int w, lat, iss0;
      @(negedge clk);
      resp_en = v.resp_en;
      req_v[v.id] = 1'b1;
      req_op[v.id] = v.op;
      req_data[v.id*32 +: 32] = v.data;
      req_rd[v.id*5 +: 5] = v.rd;
      #1;
      w = 0;
      while (!req_ready[v.id] && w < 20) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk(tag, "grant", 32'(req_ready), 32'(oh(v.id)));
      iss0 = issue_cnt;
      @(negedge clk);
      req_v[v.id] = 1'b0;
      lat = 1;
      heap_busy = (v.nbusy > 0) && (lat <= SETTLE_CYC + v.nbusy);
      while (rsp_v == '0 && lat < 60) begin
         @(negedge clk);
         lat++;
         heap_busy = (v.nbusy > 0) && (lat <= SETTLE_CYC + v.nbusy);
      end
      heap_busy = 1'b0;
      $display("txn %s id=%0d op=%0d lat=%0d rsp_v=%b rd=%0d data=%0h err=%0b occ=%0d",
               tag, v.id, v.op, lat, rsp_v, rsp_rd, rsp_data, rsp_err, occupancy);
      chk(tag, "latency", 32'(lat), 32'(v.lat));
      chk(tag, "rsp_v", 32'(rsp_v), 32'(oh(v.id)));
      chk(tag, "rsp_rd", 32'(rsp_rd), 32'(v.rd));
      chk(tag, "rsp_err", 32'(rsp_err), 32'(v.err));
      if (v.chk_data) chk(tag, "rsp_data", rsp_data, v.rdata);
      chk(tag, "occupancy", 32'(occupancy), 32'(v.occ));
      chk(tag, "heap_issues", 32'(issue_cnt - iss0), 32'(v.iss));
   endtask

   vec_t tbl[11];
   vec_t f;

   initial begin
      int w, ngr, nrs, cyc;
      //          id op data  rd nbusy en lat err chk rdata occ iss
      tbl[0]  = '{0, 1'b0, 32'd5,  5'd1,  0, 1'b1, 8,  1'b0, 1'b1, 32'd5,  1, 1};
      tbl[1]  = '{0, 1'b0, 32'd9,  5'd2,  0, 1'b1, 8,  1'b0, 1'b1, 32'd9,  2, 1};
      tbl[2]  = '{0, 1'b0, 32'd3,  5'd3,  0, 1'b1, 8,  1'b0, 1'b1, 32'd3,  3, 1};
      tbl[3]  = '{0, 1'b1, 32'd0,  5'd4,  0, 1'b1, 9,  1'b0, 1'b1, 32'd9,  2, 1};
      tbl[4]  = '{0, 1'b1, 32'd0,  5'd5,  0, 1'b1, 9,  1'b0, 1'b1, 32'd5,  1, 1};
      tbl[5]  = '{1, 1'b1, 32'd0,  5'd6,  0, 1'b1, 9,  1'b0, 1'b1, 32'd3,  0, 1};
      tbl[6]  = '{0, 1'b1, 32'd0,  5'd7,  0, 1'b1, 1,  1'b1, 1'b1, 32'd0,  0, 0};
      tbl[7]  = '{1, 1'b0, 32'd42, 5'd8,  3, 1'b1, 11, 1'b0, 1'b1, 32'd42, 1, 1};
      tbl[8]  = '{1, 1'b1, 32'd0,  5'd9,  0, 1'b0, 16, 1'b1, 1'b1, 32'd0,  0, 1};
      tbl[9]  = '{0, 1'b0, 32'd17, 5'd10, 0, 1'b1, 8,  1'b0, 1'b1, 32'd17, 1, 1};
      tbl[10] = '{0, 1'b1, 32'd0,  5'd11, 0, 1'b1, 9,  1'b0, 1'b1, 32'd17, 0, 1};

      reset = 1'b1;
      req_v = '0; req_op = '0; req_data = '0; req_rd = '0;
      heap_busy = 1'b0; resp_en = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset", "req_ready", 32'(req_ready), 32'd0);
      chk("reset", "heap_in_v", 32'(heap_in_v), 32'd0);
      chk("reset", "heap_rd", 32'(heap_rd), 32'd0);
      chk("reset", "heap_in_data", heap_in_data, 32'd0);
      chk("reset", "rsp_v", 32'(rsp_v), 32'd0);
      chk("reset", "rsp_rd", 32'(rsp_rd), 32'd0);
      chk("reset", "rsp_data", rsp_data, 32'd0);
      chk("reset", "rsp_err", 32'(rsp_err), 32'd0);
      chk("reset", "occupancy", 32'(occupancy), 32'd0);

      // Both requesters hold req_v: grants and responses alternate 0,1,0,1.
      req_v = 2'b11; req_op = 2'b00;
      req_data = {32'd20, 32'd10};
      req_rd = {5'd20, 5'd10};
      ngr = 0; nrs = 0; cyc = 0;
      while (nrs < 4 && cyc < 200) begin
         #1;
         if (rsp_v != '0) begin
            $display("txn alt rsp_v=%b rd=%0d data=%0d", rsp_v, rsp_rd, rsp_data);
            chk("alt", "rsp_owner", 32'(rsp_v), 32'(oh(nrs % 2)));
            chk("alt", "rsp_rd", 32'(rsp_rd), (nrs % 2) ? 32'd20 : 32'd10);
            chk("alt", "rsp_data", rsp_data, (nrs % 2) ? 32'd20 : 32'd10);
            nrs++;
         end
         if (req_ready != '0) begin
            chk("alt", "grant", 32'(req_ready), 32'(oh(ngr % 2)));
            ngr++;
         end
         if (nrs < 4) begin
            @(negedge clk);
            cyc++;
         end
      end
      req_v = '0;
      chk("alt", "responses", 32'(nrs), 32'd4);
      chk("alt", "grants", 32'(ngr), 32'd4);
      chk("alt", "occupancy", 32'(occupancy), 32'd4);

      // Pop left waiting for the heap, then reset lands in WAIT_RSP.
      @(negedge clk);
      resp_en = 1'b0;
      req_v[0] = 1'b1; req_op[0] = 1'b1;
      req_data[31:0] = 32'h0000abcd; req_rd[4:0] = 5'd30;
      #1;
      w = 0;
      while (!req_ready[0] && w < 20) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("rst_mid", "grant", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mid", "occ_before", 32'(occupancy), 32'd3);
      #2 reset = 1'b1;
      #1;
      $display("txn rst_mid in_v=%b rd=%0d in_data=%0h rsp_v=%b occ=%0d", heap_in_v, heap_rd, heap_in_data, rsp_v, occupancy);
      chk("rst_mid", "heap_in_v", 32'(heap_in_v), 32'd0);
      chk("rst_mid", "heap_rd", 32'(heap_rd), 32'd0);
      chk("rst_mid", "heap_in_data", heap_in_data, 32'd0);
      chk("rst_mid", "rsp_v", 32'(rsp_v), 32'd0);
      chk("rst_mid", "rsp_rd", 32'(rsp_rd), 32'd0);
      chk("rst_mid", "rsp_data", rsp_data, 32'd0);
      chk("rst_mid", "rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_mid", "occupancy", 32'(occupancy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      resp_en = 1'b1;

      for (int i = 0; i < 11; i++) exec(tbl[i], $sformatf("vec%0d", i));

      // Fill to capacity, then an overflow push and a pop from the full heap.
      for (int i = 0; i < HEAP_SIZE; i++) begin
         f = '{0, 1'b0, 32'(100 + i), 5'(i), 0, 1'b1, 8, 1'b0, 1'b1, 32'(100 + i), i + 1, 1};
         exec(f, $sformatf("fill%0d", i));
      end
      f = '{1, 1'b0, 32'd7, 5'd26, 0, 1'b1, 1, 1'b1, 1'b0, 32'd0, 25, 0};
      exec(f, "overflow");
      f = '{1, 1'b1, 32'd0, 5'd27, 0, 1'b1, 9, 1'b0, 1'b1, 32'd124, 24, 1};
      exec(f, "pop_full");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
